sdpram_wr_packer: RTL and testbench

SDPRAM_WR_PACKER -- requirements
Module: sdpram_wr_packer

---
 rtl/sdpram_wr_packer.sv | 114 +++++++++++
 tb/tb_sdpram_wr_packer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/sdpram_wr_packer.sv
// Packs narrow beats into wide RAM writes and tracks ring occupancy.
// Stalls upstream when the ring lacks room for a full packed word.
module sdpram_wr_packer #(
  parameter int ADDR_WIDTH   = 5,
  parameter int DATA_WIDTH_R = 32,
  parameter int DATA_WIDTH_W = 64
) (
  input  logic                    wr_clk,
  input  logic                    wr_rst,
  input  logic                    s_valid,
  input  logic [DATA_WIDTH_R-1:0] s_data,
  input  logic                    s_last,
  output logic                    s_ready,
  output logic                    ena,
  output logic [ADDR_WIDTH-1:0]   addra,
  output logic [DATA_WIDTH_W-1:0] dina,
  input  logic                    rel_valid,
  input  logic [ADDR_WIDTH:0]     rel_cnt,
  output logic [ADDR_WIDTH:0]     level,
  output logic                    err
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int RATIO = DATA_WIDTH_W / DATA_WIDTH_R;
  localparam int BW    = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int LW    = ADDR_WIDTH + 2;

  typedef enum logic {FILL, WAIT_SPACE} state_t;

  state_t                  state, state_nxt;
  logic [BW-1:0]           bidx;
  logic [ADDR_WIDTH-1:0]   wptr;
  logic [DATA_WIDTH_W-1:0] pack, next_word, wr_word;
  logic                    accept, done, space, issue;
  logic [LW-1:0]           lvl_ext, lvl_sum, rel_ext;

  assign s_ready   = (state == FILL) && !wr_rst;
  assign accept    = s_valid && s_ready;
  assign done      = (bidx == BW'(RATIO - 1)) || s_last;
  assign next_word = pack
                   | (DATA_WIDTH_W'(s_data) << (int'(bidx) * DATA_WIDTH_R));
  assign lvl_ext   = {1'b0, level};
  assign rel_ext   = {1'b0, rel_cnt};
  assign space     = (LW'(DEPTH) - lvl_ext) >= LW'(RATIO);
  assign lvl_sum   = lvl_ext + (issue ? LW'(RATIO) : LW'(0));

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    wr_word   = pack;
    unique case (state)
      FILL: begin
        if (accept && done) begin
          wr_word = next_word;
          if (space) issue = 1'b1;
          else       state_nxt = WAIT_SPACE;
        end
      end
      WAIT_SPACE: begin
        if (space) begin
          issue     = 1'b1;
          state_nxt = FILL;
        end
      end
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge wr_clk) begin
    if (wr_rst) state <= FILL;
    else        state <= state_nxt;
  end

  always_ff @(posedge wr_clk) begin
    if (wr_rst) begin
      bidx  <= '0;
      pack  <= '0;
      wptr  <= '0;
      level <= '0;
      ena   <= 1'b0;
      addra <= '0;
      dina  <= '0;
      err   <= 1'b0;
    end else begin
      ena <= issue;
      if (issue) begin
        addra <= wptr;
        dina  <= wr_word;
        wptr  <= wptr + ADDR_WIDTH'(RATIO);
      end
      if (accept) begin
        if (done) begin
          bidx <= '0;
          // a word that could not issue stays in pack until space frees
          pack <= issue ? '0 : next_word;
        end else begin
          bidx <= bidx + 1'b1;
          pack <= next_word;
        end
      end else if (issue) begin
        pack <= '0;
      end
      if (rel_valid && (rel_ext > lvl_sum)) begin
        err   <= 1'b1;
        level <= '0;
      end else if (rel_valid) begin
        level <= (ADDR_WIDTH+1)'(lvl_sum - rel_ext);
      end else begin
        level <= (ADDR_WIDTH+1)'(lvl_sum);
      end
    end
  end

endmodule

// File: tb/tb_sdpram_wr_packer.sv
// Directed bench for sdpram_wr_packer.
// Hand-computed expectations, immediate assertions.
module tb_sdpram_wr_packer;

  logic        wr_clk = 1'b0;
  logic        wr_rst;
  logic        s_valid;
  logic [31:0] s_data;
  logic        s_last;
  logic        s_ready;
  logic        ena;
  logic [4:0]  addra;
  logic [63:0] dina;
  logic        rel_valid;
  logic [5:0]  rel_cnt;
  logic [5:0]  level;
  logic        err;

  int tests = 0;
  int fails = 0;

  always #5 wr_clk = ~wr_clk;

  sdpram_wr_packer dut (
    .wr_clk(wr_clk), .wr_rst(wr_rst),
    .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
    .s_ready(s_ready), .ena(ena), .addra(addra), .dina(dina),
    .rel_valid(rel_valid), .rel_cnt(rel_cnt),
    .level(level), .err(err)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge wr_clk);
    #1;
  endtask

  task automatic beat(input logic [31:0] d, input logic l);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic do_reset();
    s_valid   = 1'b0;
    rel_valid = 1'b0;
    wr_rst    = 1'b1;
    tick();
    wr_rst = 1'b0;
    #1;
  endtask

  initial begin
    s_valid   = 1'b0;
    s_data    = '0;
    s_last    = 1'b0;
    rel_valid = 1'b0;
    rel_cnt   = '0;
    wr_rst    = 1'b1;
    tick();
    tick();
    chk("rst_ready", 64'(s_ready), 64'd0);
    wr_rst = 1'b0;
    #1;
    chk("post_rst_ready", 64'(s_ready), 64'd1);
    chk("rst_ena", 64'(ena), 64'd0);
    chk("rst_addra", 64'(addra), 64'd0);
    chk("rst_dina", dina, 64'd0);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_err", 64'(err), 64'd0);

    // two-beat pack
    beat(32'h11111111, 1'b0);
    chk("pair_b0_ena", 64'(ena), 64'd0);
    beat(32'h22222222, 1'b0);
    chk("pair_ena", 64'(ena), 64'd1);
    chk("pair_addra", 64'(addra), 64'd0);
    chk("pair_dina", dina, 64'h2222222211111111);
    chk("pair_level", 64'(level), 64'd2);
    tick();
    chk("pair_pulse", 64'(ena), 64'd0);

    // partial flush
    do_reset();
    beat(32'hAAAAAAAA, 1'b1);
    chk("flush_ena", 64'(ena), 64'd1);
    chk("flush_dina", dina, 64'h00000000AAAAAAAA);
    chk("flush_addra", 64'(addra), 64'd0);
    chk("flush_level", 64'(level), 64'd2);
    beat(32'h01010101, 1'b0);
    beat(32'h02020202, 1'b0);
    chk("flush_next_addra", 64'(addra), 64'd2);
    chk("flush_next_level", 64'(level), 64'd4);

    // fill ring to full, then stall and resume
    do_reset();
    for (int i = 0; i < 32; i++) begin
      beat(32'(i), 1'b0);
      if (i % 2 == 1) begin
        chk("full_ena", 64'(ena), 64'd1);
        chk("full_addra", 64'(addra), 64'(i - 1));
        chk("full_dina", dina, {32'(i), 32'(i - 1)});
      end
    end
    chk("full_level", 64'(level), 64'd32);
    chk("full_ready", 64'(s_ready), 64'd1);
    beat(32'hC0DE0033, 1'b0);
    chk("b33_ready", 64'(s_ready), 64'd1);
    beat(32'hC0DE0034, 1'b0);
    chk("b34_ready", 64'(s_ready), 64'd0);
    chk("b34_ena", 64'(ena), 64'd0);
    tick();
    chk("stall_ready", 64'(s_ready), 64'd0);
    chk("stall_ena", 64'(ena), 64'd0);
    rel_valid = 1'b1;
    rel_cnt   = 6'd2;
    tick();
    rel_valid = 1'b0;
    chk("rel_level", 64'(level), 64'd30);
    chk("rel_ena", 64'(ena), 64'd0);
    tick();
    chk("resume_ena", 64'(ena), 64'd1);
    chk("resume_addra", 64'(addra), 64'd0);
    chk("resume_dina", dina, 64'hC0DE0034C0DE0033);
    chk("resume_level", 64'(level), 64'd32);
    chk("resume_ready", 64'(s_ready), 64'd1);

    // write and release on the same edge
    do_reset();
    for (int i = 0; i < 10; i++) beat(32'(i + 100), 1'b0);
    chk("lvl10", 64'(level), 64'd10);
    beat(32'h5A5A0000, 1'b0);
    rel_valid = 1'b1;
    rel_cnt   = 6'd4;
    beat(32'h5A5A0001, 1'b0);
    rel_valid = 1'b0;
    chk("both_level", 64'(level), 64'd8);
    chk("both_ena", 64'(ena), 64'd1);
    chk("both_addra", 64'(addra), 64'd10);

    // over-release sets sticky err
    do_reset();
    beat(32'h1, 1'b0);
    beat(32'h2, 1'b0);
    chk("ovr_pre_level", 64'(level), 64'd2);
    rel_valid = 1'b1;
    rel_cnt   = 6'd5;
    tick();
    rel_valid = 1'b0;
    chk("ovr_err", 64'(err), 64'd1);
    chk("ovr_level", 64'(level), 64'd0);
    tick();
    tick();
    tick();
    chk("ovr_err_held", 64'(err), 64'd1);
    do_reset();
    chk("ovr_err_clr", 64'(err), 64'd0);

    // reset drops a partial word
    beat(32'hDEAD0001, 1'b0);
    chk("drop_b0_ena", 64'(ena), 64'd0);
    wr_rst = 1'b1;
    s_valid = 1'b1;
    s_data  = 32'hDEAD0002;
    #1;
    chk("drop_rst_ready", 64'(s_ready), 64'd0);
    tick();
    s_valid = 1'b0;
    wr_rst  = 1'b0;
    #1;
    chk("drop_rst_ena", 64'(ena), 64'd0);
    beat(32'hBEEF0001, 1'b0);
    chk("drop_y_ena", 64'(ena), 64'd0);
    beat(32'hBEEF0002, 1'b0);
    chk("drop_z_ena", 64'(ena), 64'd1);
    chk("drop_z_addra", 64'(addra), 64'd0);
    chk("drop_z_dina", dina, 64'hBEEF0002BEEF0001);
    chk("drop_z_level", 64'(level), 64'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
